// File: rtl/mem_loader.sv
// ----------------------------------------------------------------------------
// mem_loader
//
// Purpose:
//   Byte-stream program loader. It holds the CPU core in reset, accepts a
//   framed byte stream and writes the payload into mem through mem's write
//   port. It releases the core only after a frame whose checksum is good.
//
//   Frame (little-endian): ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN payload
//   bytes, CSUM. CSUM is the 8-bit sum (mod 256) of the payload bytes only.
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       synchronous active-low reset
//   start         single-cycle pulse that begins a load frame
//   byte_in       stream data
//   byte_valid    byte_in is valid
//   byte_ready    loader accepts a byte this cycle
//   mem_we        mem write enable, one pulse per payload byte
//   mem_addr      mem write address
//   mem_din       mem write data
//   cpu_reset_n   active-low reset to the core
//   busy          frame in progress
//   done          last frame loaded with good checksum (sticky)
//   error         last frame failed (sticky)
//   bytes_written payload bytes written in the current/last frame
// ----------------------------------------------------------------------------
module mem_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int REG_WIDTH  = 8,
    parameter int MEM_DEPTH  = 2048
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [REG_WIDTH-1:0]  byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_din,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] bytes_written
);

    typedef enum logic [3:0] {
        IDLE,
        A_LO,
        A_HI,
        L_LO,
        L_HI,
        CHECK,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LOW_MASK    = ADDR_WIDTH'((1 << REG_WIDTH) - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] len;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] remaining;
    logic [REG_WIDTH-1:0]  sum;
    logic [ADDR_WIDTH:0]   end_addr;
    logic [ADDR_WIDTH-1:0] byte_low;
    logic [ADDR_WIDTH-1:0] byte_high;
    logic                  transfer;

    // The extra bit on end_addr keeps a frame that would run past the top of
    // the address space from aliasing back into a small, legal-looking value.
    assign end_addr  = {1'b0, base_addr} + {1'b0, len};
    assign byte_low  = ADDR_WIDTH'(byte_in);
    assign byte_high = ADDR_WIDTH'(byte_in) << REG_WIDTH;
    assign transfer  = byte_valid && byte_ready;

    // Single-process FSM. byte_ready is registered and updated on every
    // transition so that it always matches the state being entered.
    // mem_we defaults low each cycle, so it only pulses on a payload transfer;
    // mem_addr/mem_din are left untouched otherwise and hold their last value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            byte_ready    <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_din       <= '0;
            cpu_reset_n   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            bytes_written <= '0;
            base_addr     <= '0;
            len           <= '0;
            cur_addr      <= '0;
            remaining     <= '0;
            sum           <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state         <= A_LO;
                        byte_ready    <= 1'b1;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        cpu_reset_n   <= 1'b0;
                        bytes_written <= '0;
                        sum           <= '0;
                    end
                end
                A_LO: begin
                    if (transfer) begin
                        base_addr <= (base_addr & ~LOW_MASK) | byte_low;
                        state     <= A_HI;
                    end
                end
                A_HI: begin
                    if (transfer) begin
                        base_addr <= (base_addr & LOW_MASK) | byte_high;
                        state     <= L_LO;
                    end
                end
                L_LO: begin
                    if (transfer) begin
                        len   <= (len & ~LOW_MASK) | byte_low;
                        state <= L_HI;
                    end
                end
                L_HI: begin
                    if (transfer) begin
                        len        <= (len & LOW_MASK) | byte_high;
                        state      <= CHECK;
                        byte_ready <= 1'b0;
                    end
                end
                CHECK: begin
                    cur_addr  <= base_addr;
                    remaining <= len;
                    if (end_addr > DEPTH_LIMIT) begin
                        state <= ERR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else if (len == '0) begin
                        state      <= CSUM;
                        byte_ready <= 1'b1;
                    end else begin
                        state      <= DATA;
                        byte_ready <= 1'b1;
                    end
                end
                DATA: begin
                    if (transfer) begin
                        mem_we        <= 1'b1;
                        mem_addr      <= cur_addr;
                        mem_din       <= byte_in;
                        cur_addr      <= cur_addr + 1'b1;
                        remaining     <= remaining - 1'b1;
                        sum           <= sum + byte_in;
                        bytes_written <= bytes_written + 1'b1;
                        if (remaining == ADDR_WIDTH'(1)) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (transfer) begin
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        if (byte_in == sum) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            cpu_reset_n <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
